// File: rtl/had_mult_arb.sv
// Round-robin arbiter/sequencer in front of the shared 32-lane Hadamard multiplier.
// Grants one requester, registers its operands, captures the product and returns it tagged.
module had_mult_arb #(
  parameter int W     = 1024,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [W-1:0]     req0_x,
  input  logic [W-1:0]     req0_y,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [W-1:0]     req1_x,
  input  logic [W-1:0]     req1_y,
  output logic [W-1:0]     mul_x,
  output logic [W-1:0]     mul_y,
  input  logic [W-1:0]     mul_z,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [W-1:0]     res_z,
  output logic             res_id,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);

  typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;

  state_t state, state_nxt;
  logic   last_id;   // also serves as the grant id of the operation in flight
  logic   pick;
  logic   any_req;
  logic   grant;
  logic   accept;

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    any_req = req0_valid | req1_valid;
    pick    = req1_valid;
    if (req0_valid && req1_valid) pick = ~last_id;
    accept  = (state == DONE) && res_ready;
    // Readies are gated by reset so nothing is granted while rst_n is held low.
    grant   = rst_n && any_req && ((state == IDLE) || accept);

    state_nxt = state;
    unique case (state)
      IDLE:    if (any_req) state_nxt = MULT;
      MULT:    state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = any_req ? MULT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign req0_ready = grant & ~pick;
  assign req1_ready = grant &  pick;
  assign res_valid  = (state == DONE);
  assign busy       = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last_id  <= 1'b1;
      mul_x    <= '0;
      mul_y    <= '0;
      res_z    <= '0;
      res_id   <= 1'b0;
      done_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        last_id <= pick;
        mul_x   <= pick ? req1_x : req0_x;
        mul_y   <= pick ? req1_y : req0_y;
      end
      if (state == MULT) begin
        res_z  <= mul_z;
        res_id <= last_id;
      end
      if (accept) done_cnt <= done_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_had_mult_arb.sv
// Directed bench for had_mult_arb with a behavioural Q8.24 lane multiplier on the mul_* ports.
module tb_had_mult_arb;
  localparam int W     = 1024;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0]     req0_x, req0_y, req1_x, req1_y;
  logic [W-1:0]     mul_x, mul_y, mul_z, res_z;
  logic             res_valid, res_ready, res_id, busy;
  logic [CNT_W-1:0] done_cnt;

  int               total = 0;
  int               bad   = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  had_mult_arb #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y),
    .mul_x(mul_x), .mul_y(mul_y), .mul_z(mul_z),
    .res_valid(res_valid), .res_ready(res_ready), .res_z(res_z), .res_id(res_id),
    .busy(busy), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] lane_mul(input logic signed [31:0] a, input logic signed [31:0] b);
    logic signed [63:0] p;
    p = 64'(a) * 64'(b);
    return {p[63], p[54:24]};
  endfunction

  always_comb begin
    mul_z = '0;
    for (int i = 0; i < 32; i++) mul_z[i*32 +: 32] = lane_mul(mul_x[i*32 +: 32], mul_y[i*32 +: 32]);
  end

  function automatic logic [W-1:0] vec2(input logic [31:0] a0, input logic [31:0] a5);
    logic [W-1:0] v;
    v = '0;
    v[31:0]       = a0;
    v[5*32 +: 32] = a5;
    return v;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // One uncontested operation from idle: checks grant, two-cycle latency, payload and counter.
  task automatic do_op(input logic port, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] exp_z);
    int n;
    @(negedge clk);
    res_ready = 1'b1;
    if (port) begin req1_valid = 1'b1; req1_x = x; req1_y = y; end
    else      begin req0_valid = 1'b1; req0_x = x; req0_y = y; end
    #1;
    n = 0;
    while (!(port ? req1_ready : req0_ready) && n < 8) begin
      @(negedge clk); #1; n++;
    end
    check("op_grant_wait", n, 0);
    check("op_other_ready", port ? req0_ready : req1_ready, 0);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    check("op_mult_no_valid", res_valid, 0);
    @(negedge clk); #1;
    check("op_latency", res_valid, 1);
    check("op_res_z", res_z, exp_z);
    check("op_res_id", res_id, port);
    exp_cnt++;
    @(negedge clk); #1;
    check("op_done_cnt", done_cnt, exp_cnt);
    check("op_idle", busy, 0);
  endtask

  typedef struct {
    logic        port;
    logic [31:0] x0, y0, x5, y5;
    logic [31:0] z0, z5;
  } vec_t;

  vec_t vecs[4];
  int   g_cnt, r_cnt;

  initial begin
    vecs[0] = '{1'b0, 32'h02000000, 32'h03000000, 32'h00000000, 32'h00000000, 32'h06000000, 32'h00000000};
    vecs[1] = '{1'b1, 32'hFE800000, 32'h02000000, 32'h01000000, 32'h00800000, 32'hFD000000, 32'h00800000};
    // 100.0 x 2.0 overflows Q8.24; the 64-bit product sign is kept, so the wrap lands at 0x48000000.
    vecs[2] = '{1'b0, 32'h64000000, 32'h02000000, 32'hFF000000, 32'hFF000000, 32'h48000000, 32'h01000000};
    vecs[3] = '{1'b1, 32'h00400000, 32'hFC000000, 32'h00000001, 32'h01000000, 32'hFF000000, 32'h00000001};

    rst_n = 1'b0; res_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_x = vec2(32'h11111111, 0); req0_y = vec2(32'h22222222, 0);
    req1_x = '0; req1_y = '0;
    #12;
    check("rst_res_valid", res_valid, 0);
    check("rst_res_z", res_z, 0);
    check("rst_res_id", res_id, 0);
    check("rst_mul_x", mul_x, 0);
    check("rst_mul_y", mul_y, 0);
    check("rst_done_cnt", done_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", {req0_ready, req1_ready}, 0);
    @(negedge clk);
    rst_n = 1'b1; req0_valid = 1'b0;
    #1;
    check("idle_no_ready", {req0_ready, req1_ready}, 0);

    for (int i = 0; i < 4; i++) begin
      do_op(vecs[i].port, vec2(vecs[i].x0, vecs[i].x5), vec2(vecs[i].y0, vecs[i].y5),
            vec2(vecs[i].z0, vecs[i].z5));
      @(negedge clk); #1;
      check("mul_x_hold", mul_x, vec2(vecs[i].x0, vecs[i].x5));
      check("mul_y_hold", mul_y, vec2(vecs[i].y0, vecs[i].y5));
    end

    // Contention: both requesting continuously, results chained back to back.
    req0_x = vec2(32'h01000000, 0); req0_y = vec2(32'h01000000, 0);
    req1_x = vec2(32'h02000000, 0); req1_y = vec2(32'h01000000, 0);
    res_ready = 1'b1;
    g_cnt = 0; r_cnt = 0;
    for (int c = 0; c < 40 && r_cnt < 6; c++) begin
      @(negedge clk);
      req0_valid = (g_cnt < 6); req1_valid = (g_cnt < 6);
      #1;
      check("cont_one_hot", req0_ready && req1_ready, 0);
      if (req0_ready || req1_ready) begin
        check("cont_grant_order", req1_ready, g_cnt % 2);
        g_cnt++;
      end
      if (res_valid) begin
        check("cont_res_id", res_id, r_cnt % 2);
        check("cont_res_z", res_z, vec2((r_cnt % 2) ? 32'h02000000 : 32'h01000000, 0));
        r_cnt++;
        exp_cnt++;
      end
    end
    check("cont_results", r_cnt, 6);
    @(negedge clk); #1;
    check("cont_done_cnt", done_cnt, exp_cnt);
    check("cont_idle", busy, 0);

    // Backpressure: result held in DONE, no grants until res_ready returns.
    @(negedge clk);
    res_ready = 1'b0; req1_valid = 1'b1;
    req1_x = vec2(32'h03000000, 0); req1_y = vec2(32'h02000000, 0);
    #1;
    check("bp_grant", {req0_ready, req1_ready}, 2'b01);
    @(negedge clk);
    req0_valid = 1'b1; req0_x = vec2(32'h01000000, 0); req0_y = vec2(32'h04000000, 0);
    #1;
    check("bp_mult_no_ready", {req0_ready, req1_ready}, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check("bp_res_valid", res_valid, 1);
      check("bp_res_z", res_z, vec2(32'h06000000, 0));
      check("bp_res_id", res_id, 1);
      check("bp_no_ready", {req0_ready, req1_ready}, 0);
      check("bp_done_cnt", done_cnt, exp_cnt);
    end
    @(negedge clk);
    res_ready = 1'b1;
    #1;
    check("bp_release_grant", {req0_ready, req1_ready}, 2'b10);
    exp_cnt++;
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    check("bp_accept_cnt", done_cnt, exp_cnt);
    check("bp_chain_mult", res_valid, 0);
    @(negedge clk); #1;
    check("bp_chain_valid", res_valid, 1);
    check("bp_chain_id", res_id, 0);
    check("bp_chain_z", res_z, vec2(32'h04000000, 0));
    exp_cnt++;
    @(negedge clk); #1;
    check("bp_chain_cnt", done_cnt, exp_cnt);

    // Reset while the operation is in MULT.
    @(negedge clk);
    req0_valid = 1'b1; req0_x = vec2(32'h05000000, 0); req0_y = vec2(32'h01000000, 0);
    #1;
    check("rm_grant", req0_ready, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_cnt = '0;
    check("rm_res_valid", res_valid, 0);
    check("rm_busy", busy, 0);
    check("rm_mul_x", mul_x, 0);
    check("rm_res_z", res_z, 0);
    check("rm_done_cnt", done_cnt, 0);
    check("rm_ready", {req0_ready, req1_ready}, 0);
    @(negedge clk);
    rst_n = 1'b1; req0_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      check("rm_no_stray", res_valid, 0);
    end
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("rm_first_contest", {req0_ready, req1_ready}, 2'b10);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk); #1;
    check("rm_after_valid", res_valid, 1);
    check("rm_after_z", res_z, vec2(32'h05000000, 0));
    exp_cnt++;

    // Counter wrap: 17 completed operations since reset on a 4-bit counter.
    for (int i = 0; i < 16; i++) begin
      do_op(1'(i % 2), vec2(32'h01000000, 0), vec2(32'(i) << 24, 0), vec2(32'(i) << 24, 0));
    end
    check("cnt_wrap", done_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

endmodule
